conv_output_buffer: RTL and testbench

//  Downstream of controlpath/convolver. Captures each convolution result on controlpath's enable
//  and tags it with its output-map (row, col). Buffers results in a first-word-fall-through FIFO.

---
 rtl/conv_output_buffer.sv | 95 +++++++++
 tb/tb_conv_output_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/conv_output_buffer.sv
// conv_output_buffer: tags convolution results with (row, col) and buffers them in a FWFT FIFO
// behind a valid/ready port. Define CONV_RELU_EN to clamp negative results to zero before storage.
module conv_output_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int FIFO_DEPTH  = 8,
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH,
    localparam int OUT_SIZE   = IMAGE_SIZE - KERNEL_SIZE + 1,
    localparam int CW         = $clog2(OUT_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] conv_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CW-1:0]        out_row,
    output logic [CW-1:0]        out_col,
    output logic                 out_last,
    output logic                 frame_done,
    output logic                 overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = ACC_WIDTH + 2 * CW + 1;

    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_row, r_col;
    logic                 r_frame_done, r_overflow;
    logic                 w_full, w_empty, w_pop, w_push, w_col_end, w_row_end, w_last;
    logic [ACC_WIDTH-1:0] w_val;
    logic [EW-1:0]        w_head;

    assign w_full    = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
    assign w_empty   = r_wr_ptr == r_rd_ptr;
    assign w_pop     = !w_empty && out_ready;
    assign w_push    = enable && (!w_full || w_pop);
    assign w_col_end = r_col == CW'(OUT_SIZE - 1);
    assign w_row_end = r_row == CW'(OUT_SIZE - 1);
    assign w_last    = w_col_end && w_row_end;
`ifdef CONV_RELU_EN
    assign w_val = conv_in[ACC_WIDTH-1] ? '0 : conv_in;
`else
    assign w_val = conv_in;
`endif
    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    assign out_valid  = !w_empty;
    assign {out_data, out_row, out_col, out_last} = w_head;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

    // Storage is cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_val, r_row, r_col, w_last};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Coordinates advance on every enable, even when the result is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (enable) begin
            r_col <= w_col_end ? '0 : r_col + 1'b1;
            if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= enable && w_last;
            r_overflow   <= r_overflow || (enable && !w_push);
        end
    end
endmodule

// File: tb/tb_conv_output_buffer.sv
// tb_conv_output_buffer: directed stimulus feeding a scoreboard queue; a negedge monitor
// compares every presented head entry against the queue front.
module tb_conv_output_buffer;
    localparam int DEPTH = 8;
    localparam int OS    = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] conv_in = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_row, out_col;
    logic        out_last, frame_done, overflow;

    int checks = 0;
    int errors = 0;
    logic [42:0] sb[$];
    int   occ = 0;
    logic [4:0] m_row = '0, m_col = '0;
    logic m_ovf = 1'b0;
    logic m_fd = 1'b0;

    conv_output_buffer dut (
        .clk(clk), .reset(reset), .enable(enable), .conv_in(conv_in), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_val(input logic [31:0] d);
`ifdef CONV_RELU_EN
        return d[31] ? 32'd0 : d;
`else
        return d;
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_unexpected got %0h want none", out_data);
            end else begin
                chk("head", {out_data, out_row, out_col, out_last}, sb[0]);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic cycle(input logic en, input logic [31:0] d, input logic rdy);
        logic pop, push, lst;
        enable = en;
        conv_in = d;
        out_ready = rdy;
        pop  = occ > 0 && rdy;
        push = en && (occ < DEPTH || pop);
        lst  = m_row == 5'(OS - 1) && m_col == 5'(OS - 1);
        if (push) sb.push_back({exp_val(d), m_row, m_col, lst});
        if (en && !push) m_ovf = 1'b1;
        m_fd = en && lst;
        if (en) begin
            if (m_col == 5'(OS - 1)) begin
                m_col = '0;
                m_row = (m_row == 5'(OS - 1)) ? 5'd0 : m_row + 5'd1;
            end else m_col = m_col + 5'd1;
        end
        occ = occ + int'(push) - int'(pop);
        @(posedge clk);
        #1;
        chk("valid", out_valid, occ > 0);
        chk("overflow", overflow, m_ovf);
        chk("frame_done", frame_done, m_fd);
    endtask

    task automatic drain(input int n);
        repeat (n) cycle(1'b0, 32'd0, 1'b1);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tag", {out_row, out_col, out_last}, 0);
        chk("rst_fd_ovf", {frame_done, overflow}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        occ = 0;
        m_row = '0;
        m_col = '0;
        m_ovf = 1'b0;
        m_fd = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        cycle(1'b1, 32'h0000_0123, 1'b1);
        chk("first_data", out_data, 32'h123);
        chk("first_tag", {out_row, out_col}, 0);
        drain(2);

        do_reset();
        for (int i = 0; i < 25; i++) cycle(1'b1, 32'(i * 7 + 1), 1'b1);
        drain(2);

        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'(100 + i), 1'b0);
        drain(DEPTH);
        cycle(1'b1, 32'h55, 1'b0);
        chk("col_after_drop", out_col, 9);
        drain(2);

        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(200 + i), 1'b0);
        cycle(1'b1, 32'h2AA, 1'b1);
        drain(DEPTH + 1);

        do_reset();
        for (int i = 0; i < OS * OS + 1; i++) cycle(1'b1, 32'(i), 1'b1);
        drain(2);

        do_reset();
        cycle(1'b1, 32'hFFFF_FF00, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(300 + i), 1'b0);
        do_reset();
        cycle(1'b1, 32'h77, 1'b0);
        chk("post_reset_tag", {out_row, out_col}, 0);
        drain(3);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
